serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 152 +++++++++++++++
 tb/tb_serial_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Byte-wide serial transmitter: start bit, 8 data bits LSB first, stop bit.
// Defining SERIAL_TX_PARITY_EN inserts an even-parity bit between bit 7 and stop.
module serial_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       txd
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sh, sh_n;
    logic       txd_n;
    logic       done_n;
`ifdef SERIAL_TX_PARITY_EN
    logic       par, par_n;
`endif

    logic last;
    assign last  = (cnt == LAST);
    assign ready = (state == IDLE);
    assign busy  = ~ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            txd   <= 1'b1;
            done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            txd   <= txd_n;
            done  <= done_n;
`ifdef SERIAL_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    // txd is registered, so each branch computes the line level for the
    // state being entered rather than the one being left.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        txd_n   = txd;
        done_n  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (load) begin
                    state_n = START;
                    sh_n    = data;
                    cnt_n   = '0;
                    idx_n   = '0;
                    txd_n   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                    par_n   = ^data;
`endif
                end
            end
            START: begin
                if (last) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    txd_n   = sh[0];
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DATA: begin
                if (last) begin
                    cnt_n = '0;
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_n = PARITY;
                        txd_n   = par;
`else
                        state_n = STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        sh_n  = {1'b0, sh[7:1]};
                        txd_n = sh[1];
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (last) begin
                    state_n = STOP;
                    cnt_n   = '0;
                    txd_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
`endif
            STOP: begin
                if (last) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    txd_n   = 1'b1;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
                txd_n   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: one instance at CLKS_PER_BIT=4 and one at 1,
// checked cycle by cycle against a frame model built from the byte value.
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset, load, sel;
    logic [7:0] data;
    logic       ready4, busy4, done4, txd4;
    logic       ready1, busy1, done1, txd1;
    logic       ready_s, busy_s, done_s, txd_s;
    logic       load4, load1;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    assign load4   = load & ~sel;
    assign load1   = load & sel;
    assign ready_s = sel ? ready1 : ready4;
    assign busy_s  = sel ? busy1  : busy4;
    assign done_s  = sel ? done1  : done4;
    assign txd_s   = sel ? txd1   : txd4;

    serial_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .reset(reset), .load(load4), .data(data),
        .ready(ready4), .busy(busy4), .done(done4), .txd(txd4)
    );
    serial_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .load(load1), .data(data),
        .ready(ready1), .busy(busy1), .done(done1), .txd(txd1)
    );

    // Line level of bit period b of the frame carrying byte d.
    function automatic logic frame_bit(input logic [7:0] d, input int b);
        logic [10:0] f;
`ifdef SERIAL_TX_PARITY_EN
        f = {1'b1, ^d, d, 1'b0};
`else
        f = {2'b11, d, 1'b0};
`endif
        return f[b];
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int cpb();
        return sel ? 1 : 4;
    endfunction

    // Called #1 after an edge with the selected instance idle.
    task automatic send(input logic [7:0] d);
        check("ready_before_load", ready_s, 1'b1);
        data = d;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        data = 8'($urandom);
    endtask

    // Walks the whole frame from just after the accepting edge and ends in the done cycle.
    // With mutate set, a second load with different data is held through the frame.
    task automatic frame(input logic [7:0] d, input bit mutate);
        int n;
        n = NB * cpb();
        for (int k = 0; k < n; k++) begin
            if (mutate && k == cpb()) begin
                load = 1'b1;
                data = 8'hFF;
            end
            if (mutate && k == n - 2) load = 1'b0;
            check("txd_bit", txd_s, frame_bit(d, k / cpb()));
            check("busy_in_frame", busy_s, 1'b1);
            check("ready_in_frame", ready_s, 1'b0);
            check("done_in_frame", done_s, 1'b0);
            @(posedge clk); #1;
        end
        check("done_pulse", done_s, 1'b1);
        check("ready_at_done", ready_s, 1'b1);
        check("busy_at_done", busy_s, 1'b0);
        check("txd_at_done", txd_s, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_done", done_s, 1'b0);
            check("idle_txd", txd_s, 1'b1);
            check("idle_ready", ready_s, 1'b1);
            check("idle_busy", busy_s, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b1;
        load  = 1'b0;
        data  = 8'h00;
        sel   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            check("rst_txd", txd_s, 1'b1);
            check("rst_ready", ready_s, 1'b1);
            check("rst_busy", busy_s, 1'b0);
            check("rst_done", done_s, 1'b0);
        end
        sel   = 1'b0;
        reset = 1'b0;
        idle(1);

        // Basic frames, parity 0 and parity 1 bytes.
        send(8'hA5); frame(8'hA5, 1'b0); idle(1);
        send(8'h07); frame(8'h07, 1'b0); idle(1);

        // Second load with new data during the frame is ignored.
        send(8'h3C); frame(8'h3C, 1'b1); idle(2);

        // Load in the done cycle starts the next frame immediately.
        send(8'hA5); frame(8'hA5, 1'b0);
        send(8'h55); frame(8'h55, 1'b0); idle(1);

        // Reset while data bit 3 is on the line.
        send(8'hA5);
        for (int k = 0; k < 17; k++) begin
            check("pre_reset_txd", txd_s, frame_bit(8'hA5, k / 4));
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_txd", txd_s, 1'b1);
        check("abort_ready", ready_s, 1'b1);
        check("abort_busy", busy_s, 1'b0);
        check("abort_done", done_s, 1'b0);
        idle(2);
        send(8'h5A); frame(8'h5A, 1'b0); idle(1);

        // One clock per bit.
        sel = 1'b1;
        #0;
        send(8'h80); frame(8'h80, 1'b0); idle(1);

        // Random bytes on both instances, random gaps, some back-to-back.
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom_range(0, 1));
            #0;
            d = 8'($urandom);
            send(d);
            frame(d, 1'b0);
            if ($urandom_range(0, 1) == 0) idle(1 + $urandom_range(0, 2));
        end
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
